// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector with registered Mealy match pulse,
// selectable overlapping/non-overlapping mode and a saturating match counter.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(4'b1001),
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVL     = 1'b0,
  localparam int                LW          = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam logic [LW-1:0]    MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0]    RST_LEN_L = (RST_LEN > MAX_LEN) ? MAX_LEN_L : LW'(RST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Shadow configuration; length is clamped to MAX_LEN when latched.
  logic [MAX_LEN-1:0] pattern_r;
  logic [LW-1:0]      len_r;
  logic               overlap_r;

  // The oldest history bit is never compared (din supplies the newest), so it is not stored.
  logic [MAX_LEN-2:0] hist_r;
  logic [LW-1:0]      fill_r;
  logic               dout_r;
  logic [CNT_W-1:0]   count_r;
  logic               sat_r;

  logic [MAX_LEN-1:0] nxt_s;
  logic [LW:0]        fill_inc_s;
  logic [LW-1:0]      fill_nxt_s;
  logic [LW-1:0]      cfg_len_clamp_s;
  logic               cmp_s;
  logic               hit_s;
  logic [CNT_W-1:0]   count_nxt_s;

  // Match detection, fill update and config length clamp.
  always_comb begin
    nxt_s      = {hist_r, din};
    fill_inc_s = {1'b0, fill_r} + {{LW{1'b0}}, 1'b1};
    if (fill_inc_s > {1'b0, len_r}) begin
      fill_nxt_s = len_r;
    end else begin
      fill_nxt_s = fill_inc_s[LW-1:0];
    end
    cmp_s = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      cmp_s = cmp_s & ((nxt_s[i] == pattern_r[i]) | (LW'(i) >= len_r));
    end
    // A cfg_load cycle discards din, so it can never complete a match.
    if (en && !cfg_load && (len_r != {LW{1'b0}}) && (fill_inc_s >= {1'b0, len_r})) begin
      hit_s = cmp_s;
    end else begin
      hit_s = 1'b0;
    end
    if (cfg_len > MAX_LEN_L) begin
      cfg_len_clamp_s = MAX_LEN_L;
    end else begin
      cfg_len_clamp_s = cfg_len;
    end
  end

  // Saturating counter; clear takes priority over a simultaneous hit.
  always_comb begin
    if (clr_count) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (hit_s && (count_r != CNT_MAX)) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Shadow configuration register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_r <= RST_PATTERN;
      len_r     <= RST_LEN_L;
      overlap_r <= RST_OVL;
    end else if (cfg_load) begin
      pattern_r <= cfg_pattern;
      len_r     <= cfg_len_clamp_s;
      overlap_r <= cfg_overlap;
    end
  end

  // History shift register, fill tracking and registered match pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= {LW{1'b0}};
      dout_r <= 1'b0;
    end else begin
      dout_r <= hit_s;
      if (cfg_load) begin
        hist_r <= {(MAX_LEN-1){1'b0}};
        fill_r <= {LW{1'b0}};
      end else if (en) begin
        if (hit_s && !overlap_r) begin
          hist_r <= {(MAX_LEN-1){1'b0}};
          fill_r <= {LW{1'b0}};
        end else begin
          hist_r <= nxt_s[MAX_LEN-2:0];
          fill_r <= fill_nxt_s;
        end
      end
    end
  end

  // Match counter and its saturation flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      sat_r   <= (count_nxt_s == CNT_MAX);
    end
  end

  assign dout        = dout_r;
  assign match_count = count_r;
  assign count_sat   = sat_r;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog: a default instance (CNT_W=16)
// and a CNT_W=2 instance for saturation behaviour.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, din, cfg_load, cfg_overlap, clr_count;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       dout;
  logic [15:0] match_count;
  logic       count_sat;

  logic       en_b, din_b, cfg_load_b, cfg_overlap_b, clr_count_b;
  logic [7:0] cfg_pattern_b;
  logic [3:0] cfg_len_b;
  logic       dout_b;
  logic [1:0] match_count_b;
  logic       count_sat_b;

  int checks = 0;
  int errors = 0;

  seq_detect_prog u_dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .dout(dout), .match_count(match_count), .count_sat(count_sat)
  );

  seq_detect_prog #(.CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .en(en_b), .din(din_b), .cfg_load(cfg_load_b),
    .cfg_pattern(cfg_pattern_b), .cfg_len(cfg_len_b), .cfg_overlap(cfg_overlap_b),
    .clr_count(clr_count_b), .dout(dout_b), .match_count(match_count_b), .count_sat(count_sat_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Accept one bit on the default instance and check the resulting dout.
  task automatic feed(input logic b, input logic exp_dout, input string tag);
    en = 1'b1;
    din = b;
    cyc();
    chk(tag, {31'd0, dout}, {31'd0, exp_dout});
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    en = 1'b0;
    cfg_load = 1'b1;
    cfg_pattern = pat;
    cfg_len = len;
    cfg_overlap = ovl;
    cyc();
    cfg_load = 1'b0;
  endtask

  initial begin
    logic [6:0] s7;
    logic [6:0] e7;

    reset = 1'b1;
    en = 1'b0; din = 1'b0; cfg_load = 1'b0; cfg_overlap = 1'b0; clr_count = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0;
    en_b = 1'b0; din_b = 1'b0; cfg_load_b = 1'b0; cfg_overlap_b = 1'b0; clr_count_b = 1'b0;
    cfg_pattern_b = 8'h00; cfg_len_b = 4'd0;
    cyc();
    cyc();
    chk("rst_dout", {31'd0, dout}, 32'd0);
    chk("rst_count", {16'd0, match_count}, 32'd0);
    chk("rst_sat", {31'd0, count_sat}, 32'd0);
    chk("rst_b_count", {30'd0, match_count_b}, 32'd0);
    reset = 1'b0;
    cyc();

    // Reset defaults 1001 non-overlapping: one pulse after bit 4
    s7 = 7'b1001001;
    e7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) feed(s7[i], e7[i], "t1_dout");
    en = 1'b0;
    chk("t1_count", {16'd0, match_count}, 32'd1);

    // Overlapping 1001, loaded together with a count clear
    clr_count = 1'b1;
    load(8'h09, 4'd4, 1'b1);
    clr_count = 1'b0;
    chk("t2_clr_with_load", {16'd0, match_count}, 32'd0);
    e7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) feed(s7[i], e7[i], "t2_dout");
    en = 1'b0;
    chk("t2_count", {16'd0, match_count}, 32'd2);

    // len 8 pattern 10110011 with an en gap mid-stream
    load(8'b1011_0011, 4'd8, 1'b0);
    feed(1'b1, 1'b0, "t3_b1");
    feed(1'b1, 1'b0, "t3_b2");
    feed(1'b0, 1'b0, "t3_b3");
    feed(1'b1, 1'b0, "t3_b4");
    feed(1'b1, 1'b0, "t3_b5");
    en = 1'b0;
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_gap", {31'd0, dout}, 32'd0);
    end
    feed(1'b0, 1'b0, "t3_b6");
    feed(1'b0, 1'b0, "t3_b7");
    feed(1'b1, 1'b0, "t3_b8");
    feed(1'b1, 1'b1, "t3_b9");
    en = 1'b0;
    chk("t3_count", {16'd0, match_count}, 32'd3);

    // cfg_load mid-pattern discards history and the din of the load cycle
    load(8'h09, 4'd4, 1'b0);
    feed(1'b1, 1'b0, "t4_pre1");
    feed(1'b0, 1'b0, "t4_pre2");
    feed(1'b0, 1'b0, "t4_pre3");
    en = 1'b1; din = 1'b1; cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    chk("t4_load_dout", {31'd0, dout}, 32'd0);
    feed(1'b1, 1'b0, "t4_after_load");
    feed(1'b0, 1'b0, "t4_m2");
    feed(1'b0, 1'b0, "t4_m3");
    feed(1'b1, 1'b1, "t4_m4");
    en = 1'b0;
    chk("t4_count", {16'd0, match_count}, 32'd4);

    // clr_count on its own
    clr_count = 1'b1;
    cyc();
    clr_count = 1'b0;
    chk("clr_count", {16'd0, match_count}, 32'd0);

    // cfg_len 15 clamps to 8: all-ones pattern first hits on the 8th one
    load(8'hFF, 4'd15, 1'b1);
    for (int i = 0; i < 7; i++) feed(1'b1, 1'b0, "clamp_pre");
    feed(1'b1, 1'b1, "clamp_hit8");
    feed(1'b1, 1'b1, "clamp_hit9");
    en = 1'b0;
    chk("clamp_count", {16'd0, match_count}, 32'd2);

    // len 0 disables detection even though an empty compare trivially agrees
    load(8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) feed(1'b0, 1'b0, "len0_dout");
    en = 1'b0;
    chk("len0_count", {16'd0, match_count}, 32'd2);

    // CNT_W=2 saturation with a single-bit pattern
    cfg_load_b = 1'b1; cfg_pattern_b = 8'h01; cfg_len_b = 4'd1; cfg_overlap_b = 1'b1;
    cyc();
    cfg_load_b = 1'b0;
    en_b = 1'b1; din_b = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("sat_dout", {31'd0, dout_b}, 32'd1);
      chk("sat_count", {30'd0, match_count_b}, (i >= 3) ? 32'd3 : i);
      chk("sat_flag", {31'd0, count_sat_b}, (i >= 3) ? 32'd1 : 32'd0);
    end
    clr_count_b = 1'b1;
    cyc();
    clr_count_b = 1'b0;
    en_b = 1'b0;
    chk("clr_hit_dout", {31'd0, dout_b}, 32'd1);
    chk("clr_hit_count", {30'd0, match_count_b}, 32'd0);
    chk("clr_hit_sat", {31'd0, count_sat_b}, 32'd0);

    // Async reset with 1,0,0 in flight; config must return to 1001
    feed(1'b1, 1'b0, "rm_pre1");
    feed(1'b0, 1'b0, "rm_pre2");
    feed(1'b0, 1'b0, "rm_pre3");
    en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rm_async_count", {16'd0, match_count}, 32'd0);
    chk("rm_async_dout", {31'd0, dout}, 32'd0);
    cyc();
    chk("rm_held_sat", {31'd0, count_sat}, 32'd0);
    reset = 1'b0;
    feed(1'b1, 1'b0, "rm_after");
    feed(1'b0, 1'b0, "rm_m2");
    feed(1'b0, 1'b0, "rm_m3");
    feed(1'b1, 1'b1, "rm_m4");
    en = 1'b0;
    chk("rm_count", {16'd0, match_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
